uart_tx_arbiter: RTL

- Shares one UART transmitter among NUM_REQ byte-stream requesters, using round-robin arbitration with packet lock.
- A grant is held until the requester's last byte, a MAX_BURST byte limit, or an idle timeout, whichever comes first.
- Sits between requester blocks (register readback, status reporter, loopback echo of the receiver path) and the uart_tx serializer.
- Drives the serializer's single-cycle data-valid pulse and sequences on its done pulse.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// the header nibble used by the optional tag, and the serializer bit timing.
package uart_pkg;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_TAG_ENC  = 2'd1;
   localparam logic [1:0] ST_SEND_ENC = 2'd2;
   localparam logic [1:0] ST_WAIT_ENC = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_TAG  = ST_TAG_ENC,
      ST_SEND = ST_SEND_ENC,
      ST_WAIT = ST_WAIT_ENC
   } state_t;

   localparam logic [3:0] TAG_NIBBLE   = 4'hA;
   localparam int         CLKS_PER_BIT = 87;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of i_valid scanning upward
// from i_ptr+1 with wrap, so the requester at i_ptr ends up lowest priority.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_valid,
   input  logic [W-1:0] i_ptr,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   int k;

   // Scan candidates in priority order; the first hit latches o_any and blocks later ones.
   always_comb begin
      o_idx = {W{1'b0}};
      o_any = 1'b0;
      k     = 0;
      for (int i = 1; i <= N; i++) begin
         k     = (int'(i_ptr) + i) % N;
         o_idx = (i_valid[k] && !o_any) ? W'(k) : o_idx;
         o_any = o_any | i_valid[k];
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one uart_tx among NUM_REQ byte streams.
// Define UART_TX_ARB_TAG_EN to prefix every grant with header byte {A, grant}.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = 16,
   parameter int IDLE_TIMEOUT = 1024,
   localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 sys_clk,
   input  logic                 i_rst_l,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [8*NUM_REQ-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]   i_req_last,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic                 o_tx_DV,
   output logic [7:0]           o_tx_byte,
   input  logic                 i_tx_active,
   input  logic                 i_tx_done,
   output logic [GW-1:0]        o_grant_id,
   output logic                 o_busy
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   rr_q, rr_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            done_q, done_d;
   logic            tx_dv_q, tx_dv_d;
   logic [7:0]      tx_byte_q, tx_byte_d;

   logic [GW-1:0]   pick_idx;
   logic            pick_any;
   logic            sel_valid;
   logic            sel_last;
   logic [7:0]      sel_data;

   rr_arbiter #(
      .N (NUM_REQ),
      .W (GW)
   ) u_rr (
      .i_valid (i_req_valid),
      .i_ptr   (rr_q),
      .o_idx   (pick_idx),
      .o_any   (pick_any)
   );

   // Route the granted requester's byte lane and ready strobe.
   always_comb begin
      sel_valid   = 1'b0;
      sel_last    = 1'b0;
      sel_data    = 8'h00;
      o_req_ready = {NUM_REQ{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         sel_valid      = (grant_q == GW'(k)) ? i_req_valid[k]       : sel_valid;
         sel_last       = (grant_q == GW'(k)) ? i_req_last[k]        : sel_last;
         sel_data       = (grant_q == GW'(k)) ? i_req_data[8*k +: 8] : sel_data;
         o_req_ready[k] = (state_q == ST_SEND) && (grant_q == GW'(k))
                          && i_req_valid[k] && !i_tx_active;
      end
   end

   // Next-state logic; the burst limit and the last flag fold into one release flag.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      burst_d   = burst_q;
      tmo_d     = tmo_q;
      done_d    = done_q;
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               burst_d = {BW{1'b0}};
               tmo_d   = {TW{1'b0}};
`ifdef UART_TX_ARB_TAG_EN
               tx_dv_d   = 1'b1;
               tx_byte_d = {TAG_NIBBLE, 4'(pick_idx)};
               state_d   = ST_TAG;
`else
               state_d   = ST_SEND;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef UART_TX_ARB_TAG_EN
         ST_TAG: begin
            if (i_tx_done) begin
               state_d = ST_SEND;
            end else begin
               state_d = ST_TAG;
            end
         end
`endif
         ST_SEND: begin
            if (sel_valid && !i_tx_active) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = sel_data;
               done_d    = sel_last | (burst_q == BW'(MAX_BURST - 1));
               burst_d   = burst_q + BW'(1);
               tmo_d     = {TW{1'b0}};
               state_d   = ST_WAIT;
            end else if (!sel_valid) begin
               if (tmo_q == TW'(IDLE_TIMEOUT - 1)) begin
                  tmo_d   = {TW{1'b0}};
                  rr_d    = grant_q;
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_WAIT: begin
            if (i_tx_done) begin
               if (done_q) begin
                  rr_d    = grant_q;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_SEND;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge sys_clk or negedge i_rst_l) begin
      if (!i_rst_l) begin
         state_q   <= ST_IDLE;
         grant_q   <= {GW{1'b0}};
         rr_q      <= GW'(NUM_REQ - 1);
         burst_q   <= {BW{1'b0}};
         tmo_q     <= {TW{1'b0}};
         done_q    <= 1'b0;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         burst_q   <= burst_d;
         tmo_q     <= tmo_d;
         done_q    <= done_d;
         tx_dv_q   <= tx_dv_d;
         tx_byte_q <= tx_byte_d;
      end
   end

   assign o_tx_DV    = tx_dv_q;
   assign o_tx_byte  = tx_byte_q;
   assign o_grant_id = grant_q;
   assign o_busy     = (state_q != ST_IDLE);

endmodule
